// File: rtl/batalha_naval_pkg.sv
// ============================================================================
// Module   : batalha_naval_pkg
// Brief    : Shared game states and result LED codes for the battleship controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package batalha_naval_pkg;

  typedef enum logic [1:0] {
    DESLIGADO      = 2'd0,
    POSICIONAMENTO = 2'd1,
    ATAQUE         = 2'd2,
    FIM            = 2'd3
  } estado_t;

  localparam logic [1:0] LED_APAGADO  = 2'b00;
  localparam logic [1:0] LED_ACERTO   = 2'b01;
  localparam logic [1:0] LED_ERRO     = 2'b10;
  localparam logic [1:0] LED_INVALIDO = 2'b11;

endpackage

`default_nettype wire

// File: rtl/contador_piscar.sv
// ============================================================================
// Module   : contador_piscar
// Brief    : Free-running blink phase generator; phase starts high after reset
//            and toggles every PERIODO clock cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module contador_piscar #(
  parameter int PERIODO = 190
) (
  input  logic clk,
  input  logic rst,
  output logic o_fase
);

  localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_fase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_fase <= 1'b1;
    end else if (r_cnt == CW'(PERIODO - 1)) begin
      r_cnt  <= '0;
      r_fase <= ~r_fase;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign o_fase = r_fase;

endmodule

`default_nettype wire

// File: rtl/controlador_batalha_naval_param.sv
// ============================================================================
// Module   : controlador_batalha_naval_param
// Brief    : Parametrised battleship controller (layout latch, attacks, shot
//            limit, win/loss). Define PISCAR_ERROS_EN to blink misses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module controlador_batalha_naval_param
  import batalha_naval_pkg::*;
#(
  parameter int NUM_COLUNAS   = 5,
  parameter int NUM_LINHAS    = 7,
  parameter int MAX_TIROS     = 16,
  parameter int PERIODO_PISCA = 190
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               ligado,
  input  logic                               modo,
  input  logic                               carregar_tabuleiro,
  input  logic [NUM_COLUNAS*NUM_LINHAS-1:0]  tabuleiro_posicionamento,
  input  logic                               confirmar_ataque,
  input  logic [$clog2(NUM_COLUNAS)-1:0]     ataque_coluna,
  input  logic [$clog2(NUM_LINHAS)-1:0]      ataque_linha,
  output logic [NUM_COLUNAS*NUM_LINHAS-1:0]  tabuleiro_saida,
  output logic [1:0]                         ledRGB,
  output logic [$clog2(MAX_TIROS+1)-1:0]     tiros_restantes,
  output logic                               vitoria,
  output logic                               derrota
);

  localparam int NC = NUM_COLUNAS * NUM_LINHAS;
  localparam int IW = $clog2(NC);
  localparam int NW = $clog2(NC + 1);
  localparam int TW = $clog2(MAX_TIROS + 1);

  estado_t         r_estado, w_prox;
  logic [NC-1:0]   r_navios_mapa, r_acertos_mapa, r_erros_mapa, r_saida, w_saida_prox;
  logic [NW-1:0]   r_navios, r_acertos, w_pop;
  logic [TW-1:0]   r_tiros;
  logic [1:0]      r_led;
  logic            r_vitoria, r_derrota, r_ganhou_pend, r_perdeu_pend;
  logic            w_limpa, w_carrega, w_acabou, w_ataque, w_fora, w_repetido, w_navio;
  logic            w_entra_fim, w_fase_erros;
  logic [IW-1:0]   w_idx;
  logic [NC-1:0]   w_mask;

  always_ff @(posedge clock) begin
    if (reset) r_estado <= DESLIGADO;
    else       r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    if (!ligado) begin
      w_prox = DESLIGADO;
    end else begin
      case (r_estado)
        DESLIGADO:      w_prox = POSICIONAMENTO;
        POSICIONAMENTO: if (modo && r_navios != '0) w_prox = ATAQUE;
        ATAQUE: begin
          if (!modo)                               w_prox = POSICIONAMENTO;
          else if (r_ganhou_pend || r_perdeu_pend) w_prox = FIM;
        end
        FIM:            if (!modo) w_prox = POSICIONAMENTO;
        default:        w_prox = DESLIGADO;
      endcase
    end
  end

  always_comb begin
    w_limpa     = !ligado || ((r_estado == ATAQUE || r_estado == FIM) && !modo);
    w_carrega   = ligado && (r_estado == POSICIONAMENTO) && carregar_tabuleiro;
    w_acabou    = (r_acertos == r_navios) || (r_tiros == '0);
    w_ataque    = ligado && modo && (r_estado == ATAQUE) && confirmar_ataque && !w_acabou;
    w_fora      = (int'(ataque_coluna) >= NUM_COLUNAS) || (int'(ataque_linha) >= NUM_LINHAS);
    w_idx       = IW'(int'(ataque_coluna) * NUM_LINHAS + int'(ataque_linha));
    w_mask      = NC'(1) << w_idx;
    w_repetido  = |(w_mask & (r_acertos_mapa | r_erros_mapa));
    w_navio     = |(w_mask & r_navios_mapa);
    w_entra_fim = (r_estado == ATAQUE) && (w_prox == FIM);
    w_pop       = '0;
    for (int i = 0; i < NC; i++) w_pop = w_pop + NW'(tabuleiro_posicionamento[i]);
    case (r_estado)
      POSICIONAMENTO: w_saida_prox = tabuleiro_posicionamento;
      ATAQUE:         w_saida_prox = r_acertos_mapa | (r_erros_mapa & {NC{w_fase_erros}});
      FIM:            w_saida_prox = r_navios_mapa;
      default:        w_saida_prox = '0;
    endcase
  end

`ifdef PISCAR_ERROS_EN
  logic w_pisca_rst;
  assign w_pisca_rst = reset || (r_estado != ATAQUE && w_prox == ATAQUE);

  contador_piscar #(
    .PERIODO (PERIODO_PISCA)
  ) u_contador_piscar (
    .clk    (clock),
    .rst    (w_pisca_rst),
    .o_fase (w_fase_erros)
  );
`else
  // Misses are shown steadily alongside hits.
  assign w_fase_erros = (PERIODO_PISCA > 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_navios_mapa  <= '0;
      r_navios       <= '0;
      r_acertos_mapa <= '0;
      r_erros_mapa   <= '0;
      r_acertos      <= '0;
      r_tiros        <= TW'(MAX_TIROS);
      r_led          <= LED_APAGADO;
      r_vitoria      <= 1'b0;
      r_derrota      <= 1'b0;
      r_ganhou_pend  <= 1'b0;
      r_perdeu_pend  <= 1'b0;
      r_saida        <= '0;
    end else begin
      r_saida       <= w_saida_prox;
      // End of game is judged on the settled counters, one cycle after the shot.
      r_ganhou_pend <= ligado && modo && (r_estado == ATAQUE) && (r_acertos == r_navios);
      r_perdeu_pend <= ligado && modo && (r_estado == ATAQUE) && (r_tiros == '0) &&
                       (r_acertos != r_navios);
      if (w_carrega) begin
        r_navios_mapa <= tabuleiro_posicionamento;
        r_navios      <= w_pop;
      end
      if (w_limpa) begin
        r_acertos_mapa <= '0;
        r_erros_mapa   <= '0;
        r_acertos      <= '0;
        r_tiros        <= TW'(MAX_TIROS);
        r_led          <= LED_APAGADO;
        r_vitoria      <= 1'b0;
        r_derrota      <= 1'b0;
      end else begin
        if (w_ataque) begin
          if (w_fora || w_repetido) begin
            r_led <= LED_INVALIDO;
          end else if (w_navio) begin
            r_acertos_mapa <= r_acertos_mapa | w_mask;
            r_acertos      <= r_acertos + NW'(1);
            r_tiros        <= r_tiros - TW'(1);
            r_led          <= LED_ACERTO;
          end else begin
            r_erros_mapa <= r_erros_mapa | w_mask;
            r_tiros      <= r_tiros - TW'(1);
            r_led        <= LED_ERRO;
          end
        end
        if (w_entra_fim) begin
          r_vitoria <= r_ganhou_pend;
          r_derrota <= r_perdeu_pend;
        end
      end
    end
  end

  assign tabuleiro_saida = r_saida;
  assign ledRGB          = r_led;
  assign tiros_restantes = r_tiros;
  assign vitoria         = r_vitoria;
  assign derrota         = r_derrota;

endmodule

`default_nettype wire

// File: tb/tb_controlador_batalha_naval_param.sv
// Bench for the battleship controller: directed table, hand sequences, random run vs. game model.
`timescale 1ns/1ps
`default_nettype none

module tb_controlador_batalha_naval_param;

  localparam int NCOL = 5;
  localparam int NLIN = 7;
  localparam int NC   = NCOL * NLIN;
  localparam int MAXT = 16;
  localparam int PER  = 190;

  localparam int S_OFF = 0, S_POS = 1, S_ATK = 2, S_FIM = 3;
  localparam int K_NONE = 0, K_HIT = 1, K_MISS = 2;

  logic          clock = 1'b0;
  logic          reset, ligado, modo, carregar, conf;
  logic [NC-1:0] tab;
  logic [2:0]    col, lin;

  logic [NC-1:0] saida, saida2;
  logic [1:0]    led, led2;
  logic [4:0]    tiros;
  logic [1:0]    tiros2;
  logic          vit, der, vit2, der2;

  int total = 0;
  int bad   = 0;

  // Game model
  int            m_state;
  bit            m_ship [NC];
  int            m_kind [NC];
  int            m_navios, m_hits, m_shots, m_led, m_fin_age, m_bcnt;
  bit            m_vit, m_der;
  logic [NC-1:0] m_disp;

  controlador_batalha_naval_param dut (
    .clock                    (clock),
    .reset                    (reset),
    .ligado                   (ligado),
    .modo                     (modo),
    .carregar_tabuleiro       (carregar),
    .tabuleiro_posicionamento (tab),
    .confirmar_ataque         (conf),
    .ataque_coluna            (col),
    .ataque_linha             (lin),
    .tabuleiro_saida          (saida),
    .ledRGB                   (led),
    .tiros_restantes          (tiros),
    .vitoria                  (vit),
    .derrota                  (der)
  );

  controlador_batalha_naval_param #(.MAX_TIROS(2)) dut2 (
    .clock                    (clock),
    .reset                    (reset),
    .ligado                   (ligado),
    .modo                     (modo),
    .carregar_tabuleiro       (carregar),
    .tabuleiro_posicionamento (tab),
    .confirmar_ataque         (conf),
    .ataque_coluna            (col),
    .ataque_linha             (lin),
    .tabuleiro_saida          (saida2),
    .ledRGB                   (led2),
    .tiros_restantes          (tiros2),
    .vitoria                  (vit2),
    .derrota                  (der2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit blink_on();
`ifdef PISCAR_ERROS_EN
    return ((m_bcnt / PER) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [NC-1:0] view();
    logic [NC-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) begin
      case (m_state)
        S_POS:   v[i] = tab[i];
        S_ATK:   v[i] = (m_kind[i] == K_HIT) || (m_kind[i] == K_MISS && blink_on());
        S_FIM:   v[i] = m_ship[i];
        default: v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  task automatic clear_attack();
    for (int i = 0; i < NC; i++) m_kind[i] = K_NONE;
    m_hits = 0; m_shots = MAXT; m_led = 0; m_vit = 0; m_der = 0; m_fin_age = 0;
  endtask

  task automatic model_edge();
    logic [NC-1:0] nd;
    bit            fin;
    int            old_nav, idx;
    nd  = view();
    fin = (m_hits == m_navios) || (m_shots == 0);
    if (reset) begin
      m_state = S_OFF;
      for (int i = 0; i < NC; i++) m_ship[i] = 1'b0;
      m_navios = 0;
      clear_attack();
      m_disp = '0;
      m_bcnt = 0;
    end else begin
      m_disp = nd;
      m_bcnt++;
      if (!ligado) begin
        m_state = S_OFF;
        clear_attack();
      end else if (m_state == S_OFF) begin
        m_state = S_POS;
      end else if (m_state == S_POS) begin
        old_nav = m_navios;
        if (carregar) begin
          m_navios = 0;
          for (int i = 0; i < NC; i++) begin
            m_ship[i] = tab[i];
            m_navios += int'(tab[i]);
          end
        end
        if (modo && old_nav > 0) begin
          m_state = S_ATK;
          m_bcnt  = 0;
        end
      end else if (!modo) begin
        m_state = S_POS;
        clear_attack();
      end else if (m_state == S_ATK) begin
        if (fin) begin
          m_fin_age++;
          if (m_fin_age >= 2) begin
            m_state = S_FIM;
            m_vit   = (m_hits == m_navios);
            m_der   = !m_vit;
          end
        end else if (conf) begin
          if (int'(col) >= NCOL || int'(lin) >= NLIN) begin
            m_led = 3;
          end else begin
            idx = int'(col) * NLIN + int'(lin);
            if (m_kind[idx] != K_NONE) begin
              m_led = 3;
            end else if (m_ship[idx]) begin
              m_kind[idx] = K_HIT; m_hits++; m_shots--; m_led = 1;
            end else begin
              m_kind[idx] = K_MISS; m_shots--; m_led = 2;
            end
          end
        end
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    @(negedge clock);
    chk("saida",   saida, m_disp);
    chk("ledRGB",  led,   m_led);
    chk("tiros",   tiros, m_shots);
    chk("vitoria", vit,   m_vit);
    chk("derrota", der,   m_der);
  endtask

  task automatic atk(input int c, input int l);
    conf = 1'b1;
    col  = 3'(c);
    lin  = 3'(l);
    cycle();
    conf = 1'b0;
  endtask

  typedef struct {
    int         c;
    int         l;
    logic [1:0] led;
    int         tiros;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{2, 3, 2'b10, 15};
    vt[1] = '{2, 3, 2'b11, 15};
    vt[2] = '{6, 0, 2'b11, 15};
    vt[3] = '{0, 7, 2'b11, 15};
    vt[4] = '{0, 0, 2'b01, 14};
    vt[5] = '{0, 0, 2'b11, 14};
    vt[6] = '{1, 1, 2'b01, 13};

    reset = 1'b1; ligado = 1'b0; modo = 1'b0; carregar = 1'b0; conf = 1'b0;
    tab = '0; col = '0; lin = '0;
    m_state = S_OFF; m_navios = 0; m_bcnt = 0; m_disp = '0;
    for (int i = 0; i < NC; i++) m_ship[i] = 1'b0;
    clear_attack();

    @(negedge clock);
    cycle();
    chk("rst_saida", saida, 0);
    chk("rst_led", led, 0);
    chk("rst_tiros", tiros, MAXT);
    chk("rst_vit", vit, 0);
    chk("rst_der", der, 0);
    chk("rst_tiros2", tiros2, 2);

    reset = 1'b0; ligado = 1'b1;
    cycle();
    tab = '0; tab[0] = 1'b1; tab[8] = 1'b1;
    carregar = 1'b1;
    cycle();
    carregar = 1'b0;
    modo = 1'b1;
    cycle();

    for (int i = 0; i < 7; i++) begin
      atk(vt[i].c, vt[i].l);
      chk($sformatf("vec%0d_led", i), led, vt[i].led);
      chk($sformatf("vec%0d_tiros", i), tiros, vt[i].tiros);
      cycle();
    end
    chk("win_early", vit, 0);
    cycle();
    chk("win_flag", vit, 1);
    atk(3, 3);
    chk("fim_ignores_led", led, 2'b01);
    chk("fim_ignores_tiros", tiros, 13);

    modo = 1'b0;
    atk(3, 3);
    chk("modechg_led", led, 0);
    chk("modechg_tiros", tiros, MAXT);
    chk("modechg_vit", vit, 0);
    cycle();
    chk("pos_display", saida, 35'h101);
    modo = 1'b1;
    cycle();
    cycle();
    chk("maps_cleared", saida, 0);

    atk(3, 3);
    atk(4, 4);
    chk("loss_tiros2", tiros2, 0);
    chk("loss_led2", led2, 2'b10);
    cycle();
    chk("loss_early", der2, 0);
    cycle();
    chk("loss_flag", der2, 1);
    chk("loss_vit2", vit2, 0);
    atk(0, 0);
    chk("loss_ignore_led2", led2, 2'b10);
    chk("loss_ignore_tiros2", tiros2, 0);
    atk(2, 2);
    atk(2, 2);
    chk("repeat_led", led, 2'b11);
    chk("repeat_tiros", tiros, 12);

    reset = 1'b1;
    cycle();
    chk("rst2_saida", saida, 0);
    chk("rst2_led", led, 0);
    chk("rst2_tiros", tiros, MAXT);
    chk("rst2_der", der, 0);
    chk("rst2_tiros2", tiros2, 2);
    reset = 1'b0;

    for (int k = 0; k < 4000; k++) begin
      reset    = ($urandom_range(0, 299) == 0);
      ligado   = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 59) == 0) modo = ~modo;
      carregar = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0)
        for (int i = 0; i < NC; i++) tab[i] = ($urandom_range(0, 11) == 0);
      conf     = ($urandom_range(0, 2) == 0);
      col      = 3'($urandom_range(0, 5));
      lin      = 3'($urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
